// File: rtl/solenoid_drive_ctrl_if.sv
// solenoid_drive_ctrl_if: request/abort inputs and relay/arbitration outputs
// of the lock solenoid sequencer, bundled so request sources and the
// controller share one port.
interface solenoid_drive_ctrl_if;
  logic [2:0] req;
  logic       lock_now;
  logic       relay_ctrl;
  logic [2:0] grant;
  logic       busy;
  logic       done;
  logic [2:0] reject;

  // Request side: drives unlock requests and the abort, watches the relay
  modport master (
    output req, lock_now,
    input  relay_ctrl, grant, busy, done, reject
  );

  // Controller side
  modport slave (
    input  req, lock_now,
    output relay_ctrl, grant, busy, done, reject
  );
endinterface

// File: rtl/solenoid_drive_ctrl.sv
// solenoid_drive_ctrl: arbitrates unlock requests from keypad (bit0), remote
// (bit1) and service (bit2) and sequences the active-low solenoid relay
// through PULL_IN -> HOLD -> COOLDOWN to protect the coil and the supply.
// Optional feature macro: SOLENOID_PWM_HOLD_EN (hold phase is PWM'd instead
// of driven continuously).
module solenoid_drive_ctrl #(
  parameter logic [23:0] PULL_CYCLES = 24'd2_500_000,
  parameter logic [23:0] HOLD_CYCLES = 24'd8_000_000,
  parameter logic [23:0] COOL_CYCLES = 24'd5_000_000,
  parameter logic [7:0]  PWM_PERIOD  = 8'd16,
  parameter logic [7:0]  HOLD_DUTY   = 8'd6
) (
  input  logic                  hw_clk,
  input  logic                  rst,
  solenoid_drive_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULL_IN = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_COOL    = 2'd3;

  // Zero-length phases would make the terminal-count-of-1 scheme underflow.
  generate
    if (PULL_CYCLES == 24'd0 || HOLD_CYCLES == 24'd0 || COOL_CYCLES == 24'd0 ||
        PWM_PERIOD < 8'd2 || HOLD_DUTY > 8'd255) begin : g_bad_params
      $error("solenoid_drive_ctrl: cycle counts must be >= 1 and PWM_PERIOD >= 2");
    end
  endgenerate

  logic [1:0]  state_q, state_nxt;
  logic [23:0] cnt_q, cnt_nxt;
  logic [2:0]  grant_q, grant_nxt;
  logic [2:0]  reject_q, reject_nxt;
  logic        relay_q, relay_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic [2:0]  winner;
  logic        hold_on_nxt;

`ifdef SOLENOID_PWM_HOLD_EN
  logic [7:0]  pwm_q, pwm_nxt;
`endif

  // Lowest-index active requester wins arbitration
  always_comb begin
    winner = 3'b000;
    if (bus.req[0])      winner = 3'b001;
    else if (bus.req[1]) winner = 3'b010;
    else if (bus.req[2]) winner = 3'b100;
  end

  // Next-state, counter and refusal decisions for the sequencer
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    grant_nxt  = grant_q;
    reject_nxt = 3'b000;
`ifdef SOLENOID_PWM_HOLD_EN
    pwm_nxt    = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        grant_nxt = 3'b000;
        if (bus.req != 3'b000) begin
          if (bus.lock_now) begin
            reject_nxt = bus.req;
          end else begin
            grant_nxt  = winner;
            reject_nxt = bus.req & ~winner;
            state_nxt  = ST_PULL_IN;
            cnt_nxt    = PULL_CYCLES;
          end
        end
      end
      ST_PULL_IN: begin
        reject_nxt = bus.req;
        if (bus.lock_now) begin
          state_nxt = ST_COOL;
          cnt_nxt   = COOL_CYCLES;
          grant_nxt = 3'b000;
        end else if (cnt_q == 24'd1) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_CYCLES;
        end else begin
          cnt_nxt = cnt_q - 24'd1;
        end
      end
      ST_HOLD: begin
        reject_nxt = bus.req & ~grant_q;
        if (bus.lock_now) begin
          state_nxt = ST_COOL;
          cnt_nxt   = COOL_CYCLES;
          grant_nxt = 3'b000;
        end else if ((bus.req & grant_q) != 3'b000) begin
          cnt_nxt = HOLD_CYCLES;
        end else if (cnt_q == 24'd1) begin
          state_nxt = ST_COOL;
          cnt_nxt   = COOL_CYCLES;
          grant_nxt = 3'b000;
        end else begin
          cnt_nxt = cnt_q - 24'd1;
`ifdef SOLENOID_PWM_HOLD_EN
          pwm_nxt = (pwm_q >= PWM_PERIOD - 8'd1) ? 8'd0 : pwm_q + 8'd1;
`endif
        end
      end
      ST_COOL: begin
        reject_nxt = bus.req;
        grant_nxt  = 3'b000;
        if (cnt_q == 24'd1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 24'd0;
        end else begin
          cnt_nxt = cnt_q - 24'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 24'd0;
        grant_nxt = 3'b000;
      end
    endcase
  end

  // Hold-phase drive level: PWM pattern or continuously on
  always_comb begin
`ifdef SOLENOID_PWM_HOLD_EN
    hold_on_nxt = (pwm_nxt < HOLD_DUTY);
`else
    hold_on_nxt = 1'b1;
`endif
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    relay_nxt = 1'b1;
    if (state_nxt == ST_PULL_IN)   relay_nxt = 1'b0;
    else if (state_nxt == ST_HOLD) relay_nxt = ~hold_on_nxt;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_COOL) && (state_q != ST_COOL);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 24'd0;
      grant_q  <= 3'b000;
      reject_q <= 3'b000;
      relay_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      grant_q  <= grant_nxt;
      reject_q <= reject_nxt;
      relay_q  <= relay_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

`ifdef SOLENOID_PWM_HOLD_EN
  // Hold PWM phase counter, cleared on HOLD entry and on every extension
  always_ff @(posedge hw_clk) begin
    if (rst) pwm_q <= 8'd0;
    else     pwm_q <= pwm_nxt;
  end
`endif

  assign bus.relay_ctrl = relay_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.reject     = reject_q;

endmodule
